cls_sub_16bit_seq: RTL and testbench
====================================

CLS_SUB_16BIT_SEQ -- requirements
Module: cls_sub_16bit_seq

Interface
REQ-001 Parameter: WIDTH, 16, operand width; SHALL be a multiple of 4.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Port: start  in  1  request; sampled only when ready=1.
REQ-005 Port: a  in  WIDTH  minuend, captured when start is accepted.
REQ-006 Port: b  in  WIDTH  subtrahend, captured when start is accepted.
REQ-007 Port: ready  out  1  high when a new start can be accepted.
REQ-008 Port: done  out  1  one-cycle pulse marking valid result.
REQ-009 Port: diff  out  WIDTH  a - b modulo 2^WIDTH.
REQ-010 Port: borrow  out  1  1 when a < b unsigned.
REQ-011 Port: overflow  out  1  1 when a - b overflows as two's-complement signed.

Function
REQ-012 Subtraction SHALL be computed as a + ~b + 1: the first slice gets carry_start=1.
REQ-013 The block SHALL process one 4-bit nibble per cycle, LSB first, through one shared 4-bit carry-select slice.
REQ-014 Carry SHALL chain between nibbles through a carry register.
REQ-015 FSM states SHALL be IDLE, CALC, DONE.
REQ-016 IDLE with start=1 -> CALC: latch a and ~b, nibble index=0, carry=1.
REQ-017 CALC SHALL run WIDTH/4 cycles; each cycle writes one diff nibble and updates carry.
REQ-018 On the last nibble, CALC -> DONE.
REQ-019 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-020 Exception: start=1 in DONE SHALL go directly to CALC with new operands; done still pulses.
REQ-021 Latency: for WIDTH=16, done SHALL be high in the cycle after the 4th rising edge following the edge that samples start.
REQ-022 ready SHALL be 1 in IDLE and DONE, and 0 in CALC.
REQ-023 start in CALC SHALL be ignored; the captured operands SHALL be unaffected.
REQ-024 borrow SHALL be the inverse of the final carry out.
REQ-025 overflow SHALL be (a[MSB]^b[MSB]) & (a[MSB]^diff[MSB]), using the captured operands.
REQ-026 diff, borrow and overflow SHALL hold their last result until the next operation's first CALC edge.
REQ-027 diff nibbles SHALL update progressively during CALC, and SHALL be treated as valid only while done=1.
REQ-028 Equal operands SHALL give diff=0, borrow=0, overflow=0.

Reset
REQ-029 rst_n=0 SHALL immediately force: state=IDLE, ready=1, done=0, diff=0, borrow=0, overflow=0, index=0, carry=0.
REQ-030 Reset during CALC SHALL abandon the operation; no done pulse SHALL follow.
REQ-031 After reset release, the first rising edge with start=1 SHALL be accepted.

Structure
REQ-032 Shared package cls_pkg SHALL hold the FSM state encoding (IDLE, CALC, DONE) and the constant SLICE_W=4.
REQ-033 The single sub-module SHALL be the team's existing cls_4bit slice (ports a, b, carry_start, sum, carry_out), instantiated once.
REQ-034 Nibble select and diff write-back SHALL be indexed muxing in the top level.

Verification
REQ-035 a=0x0005, b=0x0003 -> diff=0x0002, borrow=0, overflow=0; done exactly at the REQ-021 cycle.
REQ-036 a=0x0000, b=0x0001 -> diff=0xFFFF, borrow=1, overflow=0.
REQ-037 a=0x8000, b=0x0001 -> diff=0x7FFF, borrow=0, overflow=1.
REQ-038 a=0x1234, b=0x1234 -> diff=0x0000, borrow=0.
REQ-038 (cont.) Then start again in the DONE cycle with a=0x00FF, b=0x0F00 -> diff=0xF1FF, borrow=1, overflow=0.
REQ-039 Start with a=0xAAAA, b=0x5555; pulse start with other operands mid-CALC -> ignored; result diff=0x5555, borrow=0, overflow=1.
REQ-040 Assert rst_n=0 on the 2nd CALC cycle -> ready=1 and outputs 0 immediately; no done pulse.
REQ-040 (cont.) The next start with a=0x0010, b=0x0001 -> diff=0x000F.

Source files
------------

// File: rtl/cls_pkg.sv
// Shared definitions for the carry-select subtractor family:
// FSM state encoding and the width of one arithmetic slice.
package cls_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : cls_pkg

// File: rtl/cls_4bit.sv
// 4-bit carry-select adder slice: both carry-in cases are computed in parallel
// and the real carry_start picks one.
module cls_4bit
    import cls_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               carry_start,
    output logic [SLICE_W-1:0] sum,
    output logic               carry_out
);

    logic [SLICE_W:0] sum_c0;
    logic [SLICE_W:0] sum_c1;

    assign sum_c0 = {1'b0, a} + {1'b0, b};
    assign sum_c1 = {1'b0, a} + {1'b0, b} + (SLICE_W + 1)'(1);

    assign {carry_out, sum} = carry_start ? sum_c1 : sum_c0;

endmodule : cls_4bit

// File: rtl/cls_sub_16bit_seq.sv
// Sequential subtractor: a - b computed as a + ~b + 1, one nibble per cycle
// LSB first through a single shared cls_4bit slice, carry held in a register.
module cls_sub_16bit_seq
    import cls_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    localparam int NIB   = WIDTH / SLICE_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] nb_q, nb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;

    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;

    // Operands are stored with b already inverted, so the slice only adds.
    assign slice_a = a_q[idx_q*SLICE_W +: SLICE_W];
    assign slice_b = nb_q[idx_q*SLICE_W +: SLICE_W];

    cls_4bit u_slice (
        .a           (slice_a),
        .b           (slice_b),
        .carry_start (carry_q),
        .sum         (slice_sum),
        .carry_out   (slice_cout)
    );

    always_comb begin
        // NOTE: every _d starts from its held value so no branch leaves it unassigned (no latch).
        state_d  = state_q;
        a_d      = a_q;
        nb_d     = nb_q;
        diff_d   = diff_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = CALC;
                    a_d     = a;
                    nb_d    = ~b;
                    idx_d   = '0;
                    carry_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                diff_d[idx_q*SLICE_W +: SLICE_W] = slice_sum;
                carry_d = slice_cout;
                if (idx_q == LAST_IDX) begin
                    state_d  = DONE;
                    idx_d    = '0;
                    borrow_d = ~slice_cout;
                    // b's sign bit is the inverse of the stored ~b sign bit.
                    ovf_d    = (a_q[WIDTH-1] ^ ~nb_q[WIDTH-1])
                             & (a_q[WIDTH-1] ^ slice_sum[SLICE_W-1]);
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d != CALC);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            nb_q     <= '0;
            diff_q   <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop updates from the same pre-edge values.
            state_q  <= state_d;
            a_q      <= a_d;
            nb_q     <= nb_d;
            diff_q   <= diff_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign ready    = ready_q;
    assign done     = done_q;
    assign diff     = diff_q;
    assign borrow   = borrow_q;
    assign overflow = ovf_q;

endmodule : cls_sub_16bit_seq

// File: tb/tb_cls_sub_16bit_seq.sv
// Directed bench for cls_sub_16bit_seq with hand-computed expected results.
module tb_cls_sub_16bit_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        ready;
    logic        done;
    logic [15:0] diff;
    logic        borrow;
    logic        overflow;

    int n_cmp;
    int n_err;

    cls_sub_16bit_seq #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .ready    (ready),
        .done     (done),
        .diff     (diff),
        .borrow   (borrow),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a request; returns 1 ns after the edge that samples it.
    task automatic launch(input logic [15:0] av, input logic [15:0] bv);
        start = 1'b1;
        a     = av;
        b     = bv;
        step();
        start = 1'b0;
    endtask

    // Called right after launch; expects done exactly 4 edges later.
    task automatic wait_result(input string tag, input logic [15:0] exp_diff,
                               input logic exp_borrow, input logic exp_ovf);
        int cycles;
        check({tag, ".ready_calc"}, ready, 1'b0);
        check({tag, ".done_calc"}, done, 1'b0);
        cycles = 0;
        while (!done && cycles < 20) begin
            step();
            cycles++;
        end
        check({tag, ".latency"}, cycles, 4);
        check({tag, ".diff"}, diff, exp_diff);
        check({tag, ".borrow"}, borrow, exp_borrow);
        check({tag, ".overflow"}, overflow, exp_ovf);
        check({tag, ".ready_done"}, ready, 1'b1);
    endtask

    // After a result: done drops after one cycle and results hold in IDLE.
    task automatic check_idle_hold(input string tag, input logic [15:0] exp_diff,
                                   input logic exp_borrow, input logic exp_ovf);
        step();
        check({tag, ".done_pulse"}, done, 1'b0);
        check({tag, ".ready_idle"}, ready, 1'b1);
        step();
        check({tag, ".diff_hold"}, diff, exp_diff);
        check({tag, ".borrow_hold"}, borrow, exp_borrow);
        check({tag, ".ovf_hold"}, overflow, exp_ovf);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int saw_done;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.ready", ready, 1'b1);
        check("rst.done", done, 1'b0);
        check("rst.diff", diff, 16'h0000);
        check("rst.borrow", borrow, 1'b0);
        check("rst.overflow", overflow, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        launch(16'h0005, 16'h0003);
        wait_result("op5m3", 16'h0002, 1'b0, 1'b0);
        check_idle_hold("op5m3", 16'h0002, 1'b0, 1'b0);

        launch(16'h0000, 16'h0001);
        wait_result("op0m1", 16'hFFFF, 1'b1, 1'b0);
        check_idle_hold("op0m1", 16'hFFFF, 1'b1, 1'b0);

        launch(16'h8000, 16'h0001);
        wait_result("op8000m1", 16'h7FFF, 1'b0, 1'b1);
        check_idle_hold("op8000m1", 16'h7FFF, 1'b0, 1'b1);

        // Back-to-back: new start accepted in the DONE cycle.
        launch(16'h1234, 16'h1234);
        wait_result("op_equal", 16'h0000, 1'b0, 1'b0);
        launch(16'h00FF, 16'h0F00);
        wait_result("op_b2b", 16'hF1FF, 1'b1, 1'b0);
        check_idle_hold("op_b2b", 16'hF1FF, 1'b1, 1'b0);

        // start pulsed mid-CALC must not disturb the running operation.
        launch(16'hAAAA, 16'h5555);
        check("ign.ready_calc", ready, 1'b0);
        step();
        start = 1'b1;
        a     = 16'h0000;
        b     = 16'hFFFF;
        step();
        start = 1'b0;
        check("ign.done_early", done, 1'b0);
        step();
        check("ign.done_early2", done, 1'b0);
        step();
        check("ign.done", done, 1'b1);
        check("ign.diff", diff, 16'h5555);
        check("ign.borrow", borrow, 1'b0);
        check("ign.overflow", overflow, 1'b1);
        check_idle_hold("ign", 16'h5555, 1'b0, 1'b1);

        // Reset in the second CALC cycle abandons the operation.
        launch(16'h1111, 16'h0001);
        step();
        #1;
        rst_n = 1'b0;
        #1;
        check("rstcalc.ready", ready, 1'b1);
        check("rstcalc.done", done, 1'b0);
        check("rstcalc.diff", diff, 16'h0000);
        check("rstcalc.borrow", borrow, 1'b0);
        check("rstcalc.overflow", overflow, 1'b0);
        saw_done = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (done) saw_done = 1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done) saw_done = 1;
        end
        check("rstcalc.no_done", saw_done, 0);
        check("rstcalc.ready_after", ready, 1'b1);

        @(negedge clk);
        launch(16'h0010, 16'h0001);
        wait_result("op10m1", 16'h000F, 1'b0, 1'b0);
        check_idle_hold("op10m1", 16'h000F, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_cls_sub_16bit_seq
